// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path (controller and aludec).
package mips_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // aluop encodings consumed by aludec
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } ctrl_state_t;

endpackage

// File: rtl/mips_mc_controller.sv
// Main control FSM of the multicycle MIPS datapath.
//
// state   | meaning
// --------+---------------------------------------------------------
// FETCH   | read instruction at PC, PC+4 -> PC; waits on mem_ready
// DECODE  | branch target precompute, dispatch on opcode
// MEMADR  | effective address = rs + SignImm
// MEMRD   | data read at ALUOut; waits on mem_ready
// MEMWB   | load data -> rt
// MEMWR   | data write at ALUOut; waits on mem_ready
// EXECUTE | R-type ALU operation
// ALUWB   | ALU result -> rd
// BRANCH  | rs - rt, PC <= ALUOut when zero
// ADDIEX  | rs + SignImm
// ADDIWB  | ALU result -> rt
// JUMP    | PC <= jump target
module mips_mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal
);

  ctrl_state_t state, state_next;

  logic mem_req_d, memwrite_d, irwrite_d, pcwrite_d, branch_d, regwrite_d, illegal_d;

  // State register; async reset lands in FETCH immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_next = S_MEMRD;
        else if (op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_ALUWB:   state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // Per-state output decode; anything not driven in a state is 0.
  always_comb begin
    mem_req_d  = 1'b0;
    memwrite_d = 1'b0;
    iord       = 1'b0;
    irwrite_d  = 1'b0;
    pcwrite_d  = 1'b0;
    branch_d   = 1'b0;
    pcsrc      = PCSRC_ALU;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    aluop      = ALUOP_ADD;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_d = 1'b0;
    illegal_d  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_d = 1'b1;
        alusrcb   = SRCB_FOUR;
        irwrite_d = mem_ready;
        pcwrite_d = mem_ready;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH2;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_d = 1'b0;
          default:                                       illegal_d = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req_d = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_d = 1'b1;
      end
      S_MEMWR: begin
        mem_req_d  = 1'b1;
        memwrite_d = 1'b1;
        iord       = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_d = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = PCSRC_ALUOUT;
        branch_d = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB: regwrite_d = 1'b1;
      S_JUMP: begin
        pcsrc     = PCSRC_JUMP;
        pcwrite_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset_n so nothing can pulse while reset is held,
  // even though FETCH would otherwise request memory.
  assign mem_req  = reset_n & mem_req_d;
  assign memwrite = reset_n & memwrite_d;
  assign irwrite  = reset_n & irwrite_d;
  assign pcwrite  = reset_n & pcwrite_d;
  assign branch   = reset_n & branch_d;
  assign pcen     = reset_n & (pcwrite_d | (branch_d & zero));
  assign regwrite = reset_n & regwrite_d;
  assign illegal  = reset_n & illegal_d;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: walks each instruction class cycle by cycle.
module tb_mips_mc_controller;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcwrite, branch, pcen;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       alusrca, regdst, memtoreg, regwrite, illegal;

  int compared   = 0;
  int mismatched = 0;

  mips_mc_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .memwrite  (memwrite),
    .iord      (iord),
    .irwrite   (irwrite),
    .pcwrite   (pcwrite),
    .branch    (branch),
    .pcen      (pcen),
    .pcsrc     (pcsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge; checks follow after #2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe bundle {mem_req,memwrite,irwrite,pcwrite,pcen,regwrite,illegal}
  function automatic logic [6:0] strobes();
    return {mem_req, memwrite, irwrite, pcwrite, pcen, regwrite, illegal};
  endfunction

  initial begin
    reset_n   = 1'b0;
    op        = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;

    // Reset held for 3 cycles with mem_ready=1
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_strobes", 32'(strobes()), 32'h0);
      chk("rst_alusrcb", 32'(alusrcb), 32'h1);
      chk("rst_state", 32'(dut.state), 32'(S_FETCH));
    end
    #1 reset_n = 1'b1;
    #1;
    // FETCH, cycle 1 after release
    chk("fetch1_strobes", 32'(strobes()), 32'b1011100);
    chk("fetch1_alusrcb", 32'(alusrcb), 32'h1);

    // lw: FETCH(above) DECODE MEMADR MEMRD MEMWB
    op = 6'b100011;
    tick(); #2;
    chk("lw_dec_state", 32'(dut.state), 32'(S_DECODE));
    chk("lw_dec_alusrcb", 32'(alusrcb), 32'h3);
    chk("lw_dec_strobes", 32'(strobes()), 32'h0);
    tick(); #2;
    chk("lw_adr_srcs", 32'({alusrca, alusrcb, aluop}), 32'b11000);
    chk("lw_adr_regwrite", 32'(regwrite), 32'h0);
    tick(); #2;
    chk("lw_rd_req", 32'({mem_req, iord, memwrite}), 32'b110);
    chk("lw_rd_regwrite", 32'(regwrite), 32'h0);
    tick(); #2;
    chk("lw_wb", 32'({regwrite, memtoreg, regdst}), 32'b110);
    tick(); #2;
    chk("lw_back_fetch", 32'(dut.state), 32'(S_FETCH));
    chk("lw_back_memtoreg", 32'(memtoreg), 32'h0);

    // beq taken
    op = 6'b000100;
    tick(); tick(); zero = 1'b1; #2;
    chk("beq_t_pcen", 32'(pcen), 32'h1);
    chk("beq_t_pcsrc", 32'(pcsrc), 32'h1);
    chk("beq_t_aluop", 32'(aluop), 32'h1);
    tick(); #2;
    chk("beq_t_fetch", 32'(dut.state), 32'(S_FETCH));

    // beq not taken
    tick(); tick(); zero = 1'b0; #2;
    chk("beq_nt_pcen", 32'(pcen), 32'h0);
    chk("beq_nt_branch", 32'(branch), 32'h1);
    chk("beq_nt_aluop", 32'(aluop), 32'h1);
    tick(); #2;
    chk("beq_nt_fetch", 32'(dut.state), 32'(S_FETCH));

    // Fetch stall 4 cycles then R-type
    op = 6'b000000;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_irwrite", 32'({irwrite, pcwrite, mem_req}), 32'b001);
      chk("stall_state", 32'(dut.state), 32'(S_FETCH));
      tick(); #1;
    end
    mem_ready = 1'b1; #1;
    chk("stall_release", 32'({irwrite, pcwrite, mem_req}), 32'b111);
    tick(); #2;
    chk("r_dec", 32'(dut.state), 32'(S_DECODE));
    tick(); #2;
    chk("r_exec", 32'({alusrca, alusrcb, aluop}), 32'b10010);
    tick(); #2;
    chk("r_wb", 32'({regwrite, regdst, memtoreg}), 32'b110);
    tick(); #2;
    chk("r_done_fetch", 32'(dut.state), 32'(S_FETCH));

    // Illegal opcode
    op = 6'b111111;
    tick(); #2;
    chk("ill_pulse", 32'(strobes()), 32'b0000001);
    chk("ill_branch", 32'({branch, iord}), 32'h0);
    tick(); #2;
    chk("ill_back", 32'(dut.state), 32'(S_FETCH));
    chk("ill_low", 32'(illegal), 32'h0);

    // addi
    op = 6'b001000;
    tick(); tick(); #2;
    chk("addi_ex", 32'({alusrca, alusrcb, aluop}), 32'b11000);
    tick(); #2;
    chk("addi_wb", 32'({regwrite, regdst, memtoreg}), 32'b100);
    tick(); #2;
    chk("addi_fetch", 32'(dut.state), 32'(S_FETCH));

    // j
    op = 6'b000010;
    tick(); tick(); #2;
    chk("j_pc", 32'({pcwrite, pcen, pcsrc}), 32'b1110);
    tick(); #2;
    chk("j_fetch", 32'(dut.state), 32'(S_FETCH));

    // sw stalled in MEMWR, then reset pulse
    op = 6'b101011;
    tick(); tick(); mem_ready = 1'b0;
    tick(); #2;
    chk("sw_wr", 32'({mem_req, memwrite, iord}), 32'b111);
    tick(); #2;
    chk("sw_wr_hold", 32'({memwrite, dut.state}), 32'({1'b1, S_MEMWR}));
    reset_n = 1'b0; #1;
    chk("sw_rst_memwrite", 32'({mem_req, memwrite}), 32'b00);
    chk("sw_rst_state", 32'(dut.state), 32'(S_FETCH));
    tick(); #2;
    chk("sw_rst_hold", 32'(strobes()), 32'h0);
    reset_n = 1'b1; mem_ready = 1'b1; #1;
    chk("sw_after_fetch", 32'({dut.state, irwrite}), 32'({S_FETCH, 1'b1}));
    chk("sw_after_regwrite", 32'(regwrite), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode and steps each instruction through fetch, decode, execute, memory and writeback states. In every state it drives the datapath mux selects, the write strobes and the 2-bit `aluop` consumed by `aludec`. A single memory port with a ready handshake lets fetch and data accesses stall for any number of cycles.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 6: opcode field from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested.
- `memwrite` out 1: access is a write.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `irwrite` out 1: load the instruction register.
- `pcwrite` out 1: unconditional PC write.
- `branch` out 1: conditional PC write.
- `pcen` out 1: `pcwrite | (branch & zero)`.
- `pcsrc` out 2: next-PC select (00 = ALU, 01 = ALUOut, 10 = jump).
- `alusrca` out 1: ALU A select (0 = PC, 1 = rs).
- `alusrcb` out 2: ALU B select (00 = rt, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `aluop` out 2: 00 = add, 01 = sub, 10 = use funct.
- `regdst` out 1: destination register select (0 = rt, 1 = rd).
- `memtoreg` out 1: register writeback data select (0 = ALUOut, 1 = Data).
- `regwrite` out 1: register file write.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Supported opcodes:
  - lw = 100011
  - sw = 101011
  - R-type = 000000
  - beq = 000100
  - addi = 001000
  - j = 000010
- Outputs are decoded from the current state. Any signal not listed for a state is 0.
- FETCH: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00; `irwrite` = `pcwrite` = `mem_ready`. Moves to DECODE when `mem_ready`=1, otherwise holds.
- DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=00. Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXECUTE
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - any other opcode → FETCH, with `illegal`=1 for this cycle
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00. Goes to MEMRD for lw, MEMWR for sw. `op` is re-sampled here; the IR is stable.
- MEMRD: `mem_req`=1, `iord`=1. Moves to MEMWB on `mem_ready`, otherwise holds.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1. Next state FETCH.
- MEMWR: `mem_req`=1, `memwrite`=1, `iord`=1. Moves to FETCH on `mem_ready`, otherwise holds; `memwrite` stays high throughout the wait.
- EXECUTE: `alusrca`=1, `alusrcb`=00, `aluop`=10. Next state ALUWB.
- ALUWB: `regdst`=1, `regwrite`=1. Next state FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01, `branch`=1. Next state FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00. Next state ADDIWB.
- ADDIWB: `regdst`=0, `regwrite`=1. Next state FETCH.
- JUMP: `pcsrc`=10, `pcwrite`=1. Next state FETCH.
- Unused state encodings must go to FETCH and drive all strobes to 0.

## Timing
- State register updates on the rising edge of `clk`; all outputs are combinational from state, `mem_ready` and `zero`.
- While `reset_n`=0:
  - state is FETCH.
  - `mem_req`, `irwrite`, `pcwrite`, `pcen`, `memwrite`, `regwrite`, `illegal` are forced to 0.
  - All selects take their FETCH values.
- Reset asserted mid-instruction (for example in MEMWR) returns to FETCH immediately; no strobe may glitch high during reset.
- Cycles per instruction with `mem_ready` tied to 1:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
- Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `irwrite` and `pcwrite` rise in FETCH only in the cycle where `mem_ready`=1, so each fetch writes the IR and PC exactly once.

## Structure
- Shared package `mips_pkg` holds:
  - opcode localparams
  - the `aluop` encodings (00/01/10)
  - the `alusrcb` and `pcsrc` encodings
  - the `ctrl_state_t` enum
- `aludec` reuses the `aluop` constants from the same package.
- No sub-module: a state register, a next-state block and an output decode block, one file.
- `aludec` sits beside this block in the controller wrapper, not inside it.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `mem_ready`=1 → all strobes 0. After release, cycle 1 shows `mem_req`=1, `irwrite`=1, `pcwrite`=1, `alusrcb`=01.
- lw (`op`=100011), `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite`=1 and `memtoreg`=1 only in cycle 5; back in FETCH at cycle 6.
- beq (`op`=000100): with `zero`=1 → `pcen`=1 and `pcsrc`=01 in cycle 3. With `zero`=0 → `pcen`=0 in cycle 3. `aluop`=01 in both cases.
- Fetch stall: `mem_ready`=0 for 4 cycles, then 1 → FETCH held 5 cycles. `irwrite` high only in the 5th cycle; the R-type instruction completes in 8 cycles total.
- Illegal `op`=111111 → `illegal`=1 for exactly one cycle in DECODE, no other strobes, FETCH on the next cycle.
- sw with `mem_ready`=0 in MEMWR, then `reset_n` pulsed low → `memwrite` drops in the same cycle; FETCH after release; no `regwrite` seen.
